spi_tx_feeder: RTL and testbench

//  Host-side front end for SPI_Master. Buffers host write bytes in a TX FIFO and launches

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_fifo.sv | 69 ++++++
 rtl/spi_tx_feeder.sv | 117 +++++++++++
 tb/tb_spi_tx_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and bus width default
package spi_pkg;

  // Byte width shared with SPI_Master so both ends agree.
  localparam int BUS_WIDTH_DEFAULT = 8;

  // Feeder FSM encoding, fixed at 2 bits.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - WIDTH x DEPTH synchronous FIFO with count, full, empty
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pushes while full and pops while empty are ignored.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers wrap naturally (DEPTH is a power of 2); count tracks net change.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// rtl/spi_tx_feeder.sv - host TX FIFO and RX holding register in front of SPI_Master
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEFAULT,
  parameter int DEPTH     = 4,
  parameter int RX_BLOCK  = 0,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Wr_DV,
  input  logic [BUS_WIDTH-1:0] i_Wr_Byte,
  output logic                 o_Wr_Ready,
  output logic                 o_Rd_DV,
  output logic [BUS_WIDTH-1:0] o_Rd_Byte,
  input  logic                 i_Rd_Ready,
  output logic                 o_Overrun,
  output logic [CW-1:0]        o_Count,
  output logic                 o_Busy,
  output logic                 o_TX_DV,
  output logic [BUS_WIDTH-1:0] o_TX_Byte,
  input  logic                 i_TX_Ready,
  input  logic [BUS_WIDTH-1:0] i_RX_Byte
);

  localparam bit BLOCK = (RX_BLOCK != 0);

  spi_state_e           state_q, state_d;
  logic                 rd_dv_q, rd_dv_d;
  logic [BUS_WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic                 overrun_q, overrun_d;
  logic                 pop, launch, capture;
  logic [BUS_WIDTH-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;

  spi_sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .push_i      (i_Wr_DV),
    .push_data_i (i_Wr_Byte),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (o_Count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign o_Wr_Ready = !fifo_full;
  assign o_TX_DV    = launch;
  assign o_TX_Byte  = launch ? fifo_head : '0;
  assign o_Rd_DV    = rd_dv_q;
  assign o_Rd_Byte  = rd_byte_q;
  assign o_Overrun  = overrun_q;
  assign o_Busy     = (state_q != IDLE) || !fifo_empty;

  // Launch sequencing: wait for master ready, pulse DV, watch ready fall then rise.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    launch  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && i_TX_Ready && !(BLOCK && rd_dv_q)) state_d = LAUNCH;
      end
      LAUNCH: begin
        launch  = 1'b1;
        pop     = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!i_TX_Ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_TX_Ready) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RX holding register: a capture wins over a read; an unread overwrite is sticky.
  always_comb begin
    rd_dv_d   = rd_dv_q;
    rd_byte_d = rd_byte_q;
    overrun_d = overrun_q;
    if (capture) begin
      rd_dv_d   = 1'b1;
      rd_byte_d = i_RX_Byte;
      if (!BLOCK && rd_dv_q && !i_Rd_Ready) overrun_d = 1'b1;
    end else if (rd_dv_q && i_Rd_Ready) begin
      rd_dv_d = 1'b0;
    end
  end

  // State and RX registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      rd_dv_q   <= 1'b0;
      rd_byte_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_dv_q   <= rd_dv_d;
      rd_byte_q <= rd_byte_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb/tb_spi_tx_feeder.sv - directed self-checking bench for spi_tx_feeder
module tb_spi_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_dv;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic       rd_dv;
  logic [7:0] rd_byte;
  logic       rd_ready;
  logic       overrun;
  logic [2:0] count;
  logic       busy;
  logic       tx_dv;
  logic [7:0] tx_byte;
  wire        tx_ready;
  logic [7:0] rx_byte;

  logic       b_wr_dv;
  logic [7:0] b_wr_byte;
  logic       b_wr_ready;
  logic       b_rd_dv;
  logic [7:0] b_rd_byte;
  logic       b_rd_ready;
  logic       b_overrun;
  logic [2:0] b_count;
  logic       b_busy;
  logic       b_tx_dv;
  logic [7:0] b_tx_byte;
  logic       b_tx_ready;
  logic [7:0] b_rx_byte;

  logic       model_ready;
  logic       hold_low;
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];

  int checks = 0;
  int errors = 0;

  assign tx_ready = model_ready & ~hold_low;

  always #5 clk = ~clk;

  spi_tx_feeder #(.BUS_WIDTH(8), .DEPTH(4), .RX_BLOCK(0)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte), .o_Wr_Ready(wr_ready),
    .o_Rd_DV(rd_dv), .o_Rd_Byte(rd_byte), .i_Rd_Ready(rd_ready), .o_Overrun(overrun),
    .o_Count(count), .o_Busy(busy), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .i_TX_Ready(tx_ready), .i_RX_Byte(rx_byte)
  );

  spi_tx_feeder #(.BUS_WIDTH(8), .DEPTH(4), .RX_BLOCK(1)) dut_blk (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(b_wr_dv), .i_Wr_Byte(b_wr_byte), .o_Wr_Ready(b_wr_ready),
    .o_Rd_DV(b_rd_dv), .o_Rd_Byte(b_rd_byte), .i_Rd_Ready(b_rd_ready), .o_Overrun(b_overrun),
    .o_Count(b_count), .o_Busy(b_busy), .o_TX_DV(b_tx_dv), .o_TX_Byte(b_tx_byte),
    .i_TX_Ready(b_tx_ready), .i_RX_Byte(b_rx_byte)
  );

  // SPI_Master stand-in: ready drops one cycle after DV, returns 16 cycles later with RX data.
  initial begin
    model_ready = 1'b1;
    rx_byte     = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        tx_log.push_back(tx_byte);
        @(posedge clk); #1 model_ready = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_byte     = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        model_ready = 1'b1;
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    @(posedge clk); #1 wr_dv = 1'b1; wr_byte = b;
    @(posedge clk); #1 wr_dv = 1'b0;
  endtask

  task automatic rd_pulse();
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
  endtask

  task automatic wait_model(input logic level, input string name);
    int n = 0;
    while (model_ready !== level && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (model_ready !== level) begin
      errors++; $display("FAIL %s timeout waiting model_ready=%0b", name, level);
    end
  endtask

  task automatic wait_rd_dv(input string name);
    int n = 0;
    @(negedge clk);
    while (rd_dv !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rd_dv !== 1'b1) begin errors++; $display("FAIL %s rd_dv got %b exp 1", name, rd_dv); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_dv, tx_byte, rd_dv, rd_byte, overrun, count, busy} !== 22'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset dv=%b txb=%h rdv=%b rdb=%h ovr=%b cnt=%0d busy=%b wrr=%b exp zeros wrr=1",
               tx_dv, tx_byte, rd_dv, rd_byte, overrun, count, busy, wr_ready);
    end
    checks++;
    if ({b_tx_dv, b_rd_dv, b_overrun, b_count, b_busy} !== 7'd0 || b_wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_blk dv=%b rdv=%b cnt=%0d wrr=%b", b_tx_dv, b_rd_dv, b_count, b_wr_ready);
    end
  endtask

  task automatic test_single();
    rx_q.push_back(8'h3C);
    wr(8'hA5);
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b0) begin errors++; $display("FAIL single_early tx_dv got %b exp 0", tx_dv); end
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'hA5 || busy !== 1'b1) begin
      errors++; $display("FAIL single_launch dv=%b byte=%h busy=%b exp 1 a5 1", tx_dv, tx_byte, busy);
    end
    wait_rd_dv("single_rx");
    checks++;
    if (rd_byte !== 8'h3C) begin errors++; $display("FAIL single_rx_byte got %h exp 3c", rd_byte); end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_dv !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_hold rd_dv=%b busy=%b exp 1 0", rd_dv, busy);
    end
    rd_pulse();
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b0) begin errors++; $display("FAIL single_consume rd_dv got %b exp 0", rd_dv); end
  endtask

  task automatic test_capture_read();
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h40);
    wr(8'h10);
    wait_rd_dv("cr_first");
    checks++;
    if (rd_byte !== 8'h20) begin errors++; $display("FAIL cr_first_byte got %h exp 20", rd_byte); end
    wr(8'h30);
    wait_model(1'b0, "cr_busy");
    wait_model(1'b1, "cr_done");
    // model_ready just rose: this is the capture cycle, so read in it.
    rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_dv !== 1'b1 || rd_byte !== 8'h40 || overrun !== 1'b0) begin
      errors++; $display("FAIL capture_read rd_dv=%b byte=%h ovr=%b exp 1 40 0", rd_dv, rd_byte, overrun);
    end
    rd_pulse();
  endtask

  task automatic test_fifo_full();
    logic [7:0] tab [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    int n = 0;
    rd_ready = 1'b1;
    hold_low = 1'b1;
    tx_log.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 wr_dv = 1'b1; wr_byte = tab[i];
      @(negedge clk);
      checks++;
      if (wr_ready !== (i < 4)) begin
        errors++; $display("FAIL full_wr_ready[%0d] got %b exp %b", i, wr_ready, (i < 4));
      end
    end
    @(posedge clk); #1 wr_dv = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || tx_log.size() != 0) begin
      errors++; $display("FAIL full_count got %0d sent %0d exp 4 0", count, tx_log.size());
    end
    hold_low = 1'b0;
    while ((tx_log.size() < 4 || busy) && n < 400) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    checks++;
    if (tx_log.size() != 4) begin
      errors++; $display("FAIL full_sent_count got %0d exp 4", tx_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_log[i] !== tab[i]) begin
          errors++; $display("FAIL full_order[%0d] got %h exp %h", i, tx_log[i], tab[i]);
        end
      end
    end
    checks++;
    if (count !== 3'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL full_drain count=%0d ovr=%b exp 0 0", count, overrun);
    end
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int n = 0;
    int dv_seen = 0;
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'hBB);
    tx_log.delete();
    wr(8'h11);
    wr(8'h22);
    while ((tx_log.size() < 2 || busy) && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || rd_byte !== 8'hBB || rd_dv !== 1'b1) begin
      errors++; $display("FAIL overrun ovr=%b byte=%h rd_dv=%b exp 1 bb 1", overrun, rd_byte, rd_dv);
    end
    // RX_BLOCK=1 instance, master handshake driven by hand.
    @(posedge clk); #1 b_wr_dv = 1'b1; b_wr_byte = 8'h11;
    @(posedge clk); #1 b_wr_byte = 8'h22;
    @(posedge clk); #1 b_wr_dv = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_tx_dv !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (b_tx_dv !== 1'b1 || b_tx_byte !== 8'h11) begin
      errors++; $display("FAIL blk_first dv=%b byte=%h exp 1 11", b_tx_dv, b_tx_byte);
    end
    @(posedge clk); #1 b_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 b_rx_byte = 8'hAA; b_tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (b_rd_dv !== 1'b1 || b_rd_byte !== 8'hAA) begin
      errors++; $display("FAIL blk_rx rd_dv=%b byte=%h exp 1 aa", b_rd_dv, b_rd_byte);
    end
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (b_tx_dv) dv_seen++; end
    checks++;
    if (dv_seen != 0 || b_count !== 3'd1) begin
      errors++; $display("FAIL blk_stall dv_seen=%0d count=%0d exp 0 1", dv_seen, b_count);
    end
    @(posedge clk); #1 b_rd_ready = 1'b1;
    @(posedge clk); #1 b_rd_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_tx_dv !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (b_tx_dv !== 1'b1 || b_tx_byte !== 8'h22 || b_overrun !== 1'b0) begin
      errors++; $display("FAIL blk_second dv=%b byte=%h ovr=%b exp 1 22 0", b_tx_dv, b_tx_byte, b_overrun);
    end
    @(posedge clk); #1 b_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 b_rx_byte = 8'hBB; b_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (b_rd_byte !== 8'hBB || b_busy !== 1'b0) begin
      errors++; $display("FAIL blk_done byte=%h busy=%b exp bb 0", b_rd_byte, b_busy);
    end
  endtask

  task automatic test_reset_mid();
    int dv_seen = 0;
    rx_q.push_back(8'h99);
    wr(8'h66);
    wait_model(1'b0, "mid_busy");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_dv, tx_byte, rd_dv, rd_byte, overrun, count, busy} !== 22'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset dv=%b rdv=%b rdb=%h ovr=%b cnt=%0d busy=%b wrr=%b exp zeros wrr=1",
               tx_dv, rd_dv, rd_byte, overrun, count, busy, wr_ready);
    end
    wait_model(1'b1, "mid_done");
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (rd_dv || tx_dv) dv_seen++; end
    checks++;
    if (dv_seen != 0) begin errors++; $display("FAIL mid_no_rx seen=%0d exp 0", dv_seen); end
    rx_q.push_back(8'h5E);
    wr(8'h77);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h77) begin
      errors++; $display("FAIL mid_relaunch dv=%b byte=%h exp 1 77", tx_dv, tx_byte);
    end
    wait_rd_dv("mid_rx");
    checks++;
    if (rd_byte !== 8'h5E || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_rx_byte byte=%h ovr=%b exp 5e 0", rd_byte, overrun);
    end
  endtask

  initial begin
    rst = 1'b1; hold_low = 1'b0;
    wr_dv = 1'b0; wr_byte = 8'h00; rd_ready = 1'b0;
    b_wr_dv = 1'b0; b_wr_byte = 8'h00; b_rd_ready = 1'b0; b_tx_ready = 1'b1; b_rx_byte = 8'h00;
    test_reset();
    test_single();
    test_capture_read();
    test_fifo_full();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
